// File: rtl/mem_responder.sv
// Byte-addressable big-endian RAM answering MOV/RW requests with MOC after WAIT_CYCLES wait states.
// Inputs are latched at acceptance; access commits on the BUSY->DONE edge; MOC held until MOV drops.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  acc_type,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        type_q;
  logic [31:0]       din_q;
  logic [7:0]        mem [2**ADDR_W];

  logic [ADDR_W-1:0] addr_al;
  logic              commit;
  logic [31:0]       rd_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W];

  // Alignment is applied once at acceptance, so every stored address is already aligned.
  always_comb begin
    addr_al = addr[ADDR_W-1:0];
    case (acc_type)
      2'b00:   addr_al = addr[ADDR_W-1:0];
      2'b01:   addr_al[0] = 1'b0;
      default: addr_al[1:0] = 2'b00;
    endcase
  end

  assign commit = (state == BUSY) && mov && (cnt == 4'd0);

  // Aligned base means OR-ing the byte offset is the same as adding it.
  always_comb begin
    rd_data = 32'd0;
    case (type_q)
      2'b00:   rd_data = {24'd0, mem[addr_q]};
      2'b01:   rd_data = {16'd0, mem[addr_q], mem[addr_q | ADDR_W'(1)]};
      default: rd_data = {mem[addr_q], mem[addr_q | ADDR_W'(1)],
                          mem[addr_q | ADDR_W'(2)], mem[addr_q | ADDR_W'(3)]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && !rw_q) begin
      case (type_q)
        2'b00: mem[addr_q] <= din_q[7:0];
        2'b01: begin
          mem[addr_q]               <= din_q[15:8];
          mem[addr_q | ADDR_W'(1)]  <= din_q[7:0];
        end
        default: begin
          mem[addr_q]               <= din_q[31:24];
          mem[addr_q | ADDR_W'(1)]  <= din_q[23:16];
          mem[addr_q | ADDR_W'(2)]  <= din_q[15:8];
          mem[addr_q | ADDR_W'(3)]  <= din_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      moc      <= 1'b0;
      data_out <= 32'd0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      type_q   <= 2'b00;
      din_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          moc <= 1'b0;
          if (mov) begin
            addr_q <= addr_al;
            rw_q   <= rw;
            type_q <= acc_type;
            din_q  <= data_in;
            cnt    <= 4'(WAIT_CYCLES);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (!mov) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            if (rw_q) data_out <= rd_data;
            moc   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!mov) begin
            moc   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          moc   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, handshake/abort/reset sequences, random traffic vs a byte-array model.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        mov;
  logic        rw;
  logic [1:0]  acc_type;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out, data_out2;
  logic        moc, moc2;

  int total = 0;
  int bad   = 0;

  bit [7:0]  model [512];
  bit [31:0] last_rd;

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mov(mov), .rw(rw), .acc_type(acc_type),
    .addr(addr), .data_in(data_in), .data_out(data_out), .moc(moc)
  );

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0w (
    .clk(clk), .rst_n(rst_n), .mov(mov), .rw(rw), .acc_type(acc_type),
    .addr(addr), .data_in(data_in), .data_out(data_out2), .moc(moc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic int nbytes(input bit [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int base_of(input bit [31:0] a, input bit [1:0] sz);
    int unsigned b;
    b = a % 512;
    return int'(b - (b % nbytes(sz)));
  endfunction

  function automatic bit [31:0] ref_read(input bit [1:0] sz, input bit [31:0] a);
    bit [31:0] v;
    int b;
    v = 0;
    b = base_of(a, sz);
    for (int i = 0; i < nbytes(sz); i++) v = (v << 8) | 32'(model[b + i]);
    return v;
  endfunction

  function automatic void ref_write(input bit [1:0] sz, input bit [31:0] a, input bit [31:0] d);
    int b, n;
    b = base_of(a, sz);
    n = nbytes(sz);
    for (int i = 0; i < n; i++) model[b + i] = 8'(d >> (8 * (n - 1 - i)));
  endfunction

  // Full transaction on the WAIT_CYCLES=2 instance; starts and ends with the DUT idle, at a falling edge.
  task automatic xact(input bit r, input bit [1:0] sz, input bit [31:0] a, input bit [31:0] d,
                      output bit [31:0] dout);
    int lat;
    @(negedge clk);
    rw = r; acc_type = sz; addr = a; data_in = d; mov = 1'b1;
    @(posedge clk); #1;
    rw = $urandom; acc_type = 2'($urandom); addr = $urandom; data_in = $urandom;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (moc) break;
    end
    chk("latency", 32'(lat), 32'd3);
    dout = data_out;
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk); #1;
    chk("moc_fall", {31'd0, moc}, 32'd0);
  endtask

  typedef struct {
    bit        r;
    bit [1:0]  sz;
    bit [31:0] a;
    bit [31:0] d;
    bit [31:0] exp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit [31:0] dout, hold_val, prior;
    bit        r;
    bit [1:0]  sz;
    bit [31:0] a, d;

    tbl[0]  = '{1'b0, 2'b10, 32'h10,  32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, 2'b10, 32'h10,  32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'b00, 32'h10,  32'h0,        32'h000000DE};
    tbl[3]  = '{1'b1, 2'b00, 32'h13,  32'h0,        32'h000000EF};
    tbl[4]  = '{1'b0, 2'b10, 32'h20,  32'h0,        32'h0};
    tbl[5]  = '{1'b0, 2'b00, 32'h22,  32'h555555AA, 32'h0};
    tbl[6]  = '{1'b0, 2'b01, 32'h20,  32'hFFFF1234, 32'h0};
    tbl[7]  = '{1'b1, 2'b10, 32'h20,  32'h0,        32'h1234AA00};
    tbl[8]  = '{1'b0, 2'b10, 32'h33,  32'h01020304, 32'h0};
    tbl[9]  = '{1'b1, 2'b10, 32'h30,  32'h0,        32'h01020304};
    tbl[10] = '{1'b1, 2'b01, 32'h31,  32'h0,        32'h00000102};
    tbl[11] = '{1'b1, 2'b10, 32'h210, 32'h0,        32'hDEADBEEF};
    tbl[12] = '{1'b1, 2'b11, 32'hFFFF_FE12, 32'h0,  32'hDEADBEEF};

    rst_n = 1'b0; mov = 1'b0; rw = 1'b0; acc_type = 2'b00; addr = 0; data_in = 0;
    #22;
    chk("reset_moc", {31'd0, moc}, 32'd0);
    chk("reset_dout", data_out, 32'd0);
    chk("reset_moc_w0", {31'd0, moc2}, 32'd0);
    rst_n = 1'b1;
    last_rd = 32'd0;

    for (int w = 0; w < 128; w++) begin
      d = $urandom;
      xact(1'b0, 2'b10, 32'(w * 4), d, dout);
      ref_write(2'b10, 32'(w * 4), d);
    end

    for (int i = 0; i < 13; i++) begin
      xact(tbl[i].r, tbl[i].sz, tbl[i].a, tbl[i].d, dout);
      if (tbl[i].r) begin
        chk($sformatf("vec%0d_read", i), dout, tbl[i].exp);
        last_rd = tbl[i].exp;
      end else begin
        chk($sformatf("vec%0d_dout_kept", i), dout, last_rd);
        ref_write(tbl[i].sz, tbl[i].a, tbl[i].d);
      end
    end

    // Abort: MOV drops while BUSY, write must not land.
    prior = ref_read(2'b10, 32'h40);
    @(negedge clk);
    rw = 1'b0; acc_type = 2'b10; addr = 32'h40; data_in = 32'hFFFFFFFF; mov = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mov = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (moc) seen = 1'b1;
      end
      chk("abort_no_moc", {31'd0, seen}, 32'd0);
    end
    chk("abort_dout_kept", data_out, last_rd);
    xact(1'b1, 2'b10, 32'h40, 32'h0, dout);
    chk("abort_prior_data", dout, prior);
    last_rd = dout;

    // Hold MOV after DONE; then reassert one cycle after the fall on the zero-wait instance.
    hold_val = ref_read(2'b10, 32'h10);
    @(negedge clk);
    rw = 1'b1; acc_type = 2'b10; addr = 32'h10; mov = 1'b1;
    @(posedge clk); #1;
    addr = 32'h20; acc_type = 2'b00;
    @(posedge clk); #1;
    chk("w0_moc_1edge", {31'd0, moc2}, 32'd1);
    chk("w0_read", data_out2, hold_val);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_moc_rise", {31'd0, moc}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_moc", {31'd0, moc}, 32'd1);
    chk("hold_moc_w0", {31'd0, moc2}, 32'd1);
    chk("hold_dout", data_out, hold_val);
    chk("hold_dout_w0", data_out2, hold_val);
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk); #1;
    chk("hold_fall", {31'd0, moc}, 32'd0);
    chk("hold_fall_w0", {31'd0, moc2}, 32'd0);
    @(negedge clk);
    rw = 1'b1; acc_type = 2'b00; addr = 32'h13; mov = 1'b1;
    @(posedge clk); #1;
    chk("reissue_not_yet", {31'd0, moc2}, 32'd0);
    @(posedge clk); #1;
    chk("reissue_w0_moc", {31'd0, moc2}, 32'd1);
    chk("reissue_w0_data", data_out2, ref_read(2'b00, 32'h13));
    repeat (2) @(posedge clk);
    #1;
    chk("reissue_moc", {31'd0, moc}, 32'd1);
    chk("reissue_data", data_out, ref_read(2'b00, 32'h13));
    last_rd = ref_read(2'b00, 32'h13);
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      r = 1'($urandom);
      sz = 2'($urandom);
      a = $urandom;
      d = $urandom;
      xact(r, sz, a, d, dout);
      if (r) begin
        chk($sformatf("rand%0d_read", i), dout, ref_read(sz, a));
        last_rd = dout;
      end else begin
        chk($sformatf("rand%0d_dout_kept", i), dout, last_rd);
        ref_write(sz, a, d);
      end
    end

    // Reset mid-BUSY: outputs clear at once and the write is dropped.
    xact(1'b1, 2'b10, 32'h10, 32'h0, dout);
    prior = ref_read(2'b10, 32'h10);
    chk("pre_reset_read", dout, prior);
    @(negedge clk);
    rw = 1'b0; acc_type = 2'b10; addr = 32'h10; data_in = ~prior; mov = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_reset_w0_moc", {31'd0, moc2}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("areset_moc", {31'd0, moc}, 32'd0);
    chk("areset_dout", data_out, 32'd0);
    chk("areset_moc_w0", {31'd0, moc2}, 32'd0);
    mov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(1'b1, 2'b10, 32'h10, 32'h0, dout);
    chk("reset_no_write", dout, prior);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
